cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Direct-mapped, read-only cache controller with one-word lines, sitting between the CPU fetch/load port and external memory. It drives the shared index and write strobes of the valid, tag and data arrays; the valid array is the ValidRam block, with registered read and write-on-clock. It performs hit/miss lookup, a memory refill handshake, and an invalidate-all sweep that runs after reset and on request.

## Interface
- ADDR_W, 32, byte address width
- INDEX_W, 6, index width; CACHE_SIZE = 2**INDEX_W lines
- TAG_W, ADDR_W-INDEX_W-2, tag width (word-aligned addresses)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  read request
- cpu_addr  in  ADDR_W  request address, bits [1:0] ignored
- cpu_ready  out  1  request accepted this cycle when high with cpu_req
- cpu_rvalid  out  1  read data valid, one-cycle pulse
- cpu_rdata  out  32  read data
- flush  in  1  invalidate-all request, level or pulse
- mem_req  out  1  refill request
- mem_addr  out  ADDR_W  refill word address
- mem_ack  in  1  refill data valid
- mem_rdata  in  32  refill data
- ram_index  out  INDEX_W  shared array address
- valid_in  out  1  valid bit to write
- valid_write  out  1  valid array write strobe
- valid_out  in  1  valid array read, registered
- tag_in  out  TAG_W; tag_write  out  1; tag_out  in  TAG_W
- data_in  out  32; data_write  out  1; data_out  in  32

## Operation
- States: FLUSH, IDLE, LOOKUP, MISS_REQ, REFILL, RESP.
- Reset enters FLUSH with sweep counter 0. All outputs are 0 during reset, except FLUSH sweep strobes, which start on the first edge after deassertion.
- FLUSH:
  - Each cycle: ram_index = counter, valid_in = ABSENT, valid_write = 1, counter increments.
  - After index CACHE_SIZE-1 is written, go to IDLE.
  - cpu_ready = 0 throughout.
- IDLE:
  - flush (or the pending-flush flag) has priority: go to FLUSH with counter 0 and clear the flag.
  - Otherwise cpu_ready = 1, and ram_index is driven combinationally from cpu_addr index bits.
  - cpu_req && cpu_ready latches the address and goes to LOOKUP.
- LOOKUP:
  - hit = valid_out == PRESENT && tag_out == latched tag.
  - On hit: cpu_rvalid = 1, cpu_rdata = data_out, go to IDLE.
  - On miss: go to MISS_REQ.
- MISS_REQ:
  - mem_req = 1 and mem_addr = {tag, index, 2'b00}, both held stable until mem_ack.
  - On mem_ack, capture mem_rdata and go to REFILL.
- REFILL: in one cycle, write valid_in = PRESENT, tag_in, and data_in = captured word at the latched index, then go to RESP.
- RESP: cpu_rvalid = 1, cpu_rdata = captured word, go to IDLE.
- flush asserted outside IDLE/FLUSH sets a sticky pending flag. The flag is serviced on the next IDLE, before any new cpu_req.
- mem_ack outside MISS_REQ is ignored.
- Reset mid-refill abandons the request: mem_req drops immediately (asynchronously) and the FSM enters FLUSH.

## Timing
- Hit latency:
  - Accept at edge E0, RAM read at E0, cpu_rvalid high in the cycle after E0.
  - Throughput is one hit per 2 cycles.
- Miss latency: accept E0 → MISS_REQ from E1 → ack at edge Ea → REFILL → RESP, with cpu_rvalid in cycle Ea+1.
- Flush sweep takes CACHE_SIZE cycles. Post-reset, cpu_ready first rises CACHE_SIZE cycles after rst deasserts.
- At most one write strobe set per cycle, except in REFILL, where all three are set.

## Configuration
- CACHE_CTRL_STATS_EN:
  - Defined: adds output ports hit_count and miss_count (32 bits each, saturating at all-ones).
    - hit_count increments on each LOOKUP hit.
    - miss_count increments on each LOOKUP miss.
    - Both clear on rst only; flush does not clear them.
  - Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Package cache_pkg holds:
  - state enum cache_state_t
  - constants PRESENT = 1'b1, ABSENT = 1'b0
  - default INDEX_W/ADDR_W
  - a tag/index extraction function
- Sub-module cache_stats holds the two saturating counters. It is instantiated only under CACHE_CTRL_STATS_EN.

## Test plan
- Reset release:
  - valid_write is high for 64 consecutive cycles with ram_index 0..63 and valid_in = 0.
  - cpu_ready rises on cycle 65.
- Cold read of 0x0000_0104:
  - Stimulus: mem_ack 3 cycles later with 0xDEADBEEF.
  - Expect mem_addr = 0x104, tag/data/valid written at index 1, cpu_rvalid with 0xDEADBEEF.
  - miss_count = 1 when stats are enabled.
- Repeat read of 0x104: cpu_rvalid one cycle after accept, data 0xDEADBEEF, no mem_req, hit_count = 1.
- Conflict read of 0x0000_0204 (same index 1, different tag):
  - Expect a miss.
  - A following read of 0x104 misses again.
- flush pulsed during MISS_REQ:
  - The refill completes and is returned.
  - The sweep then runs before the next accept.
  - The following read of 0x104 misses.
- rst asserted while mem_req is high:
  - mem_req drops immediately.
  - A full sweep runs after release.
  - A late mem_ack is ignored.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, constants and address helpers for the direct-mapped cache controller.
package cache_pkg;

  localparam int DEFAULT_ADDR_W  = 32;
  localparam int DEFAULT_INDEX_W = 6;

  localparam logic PRESENT = 1'b1;
  localparam logic ABSENT  = 1'b0;

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    LOOKUP,
    MISS_REQ,
    REFILL,
    RESP
  } cache_state_t;

  // Helpers work on a 64-bit zero-extended byte address so any ADDR_W up to 64 fits.
  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int index_w);
    return (addr >> 2) & ((64'd1 << index_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int index_w);
    return addr >> (index_w + 2);
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU-side request/response and memory refill handshake of the cache controller.
interface cache_ctrl_if #(
  parameter int ADDR_W = cache_pkg::DEFAULT_ADDR_W
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ready;
  logic              cpu_rvalid;
  logic [31:0]       cpu_rdata;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  // master: the cache controller; slave: the CPU and memory around it.
  modport master (
    input  cpu_req, cpu_addr, mem_ack, mem_rdata,
    output cpu_ready, cpu_rvalid, cpu_rdata, mem_req, mem_addr
  );

  modport slave (
    output cpu_req, cpu_addr, mem_ack, mem_rdata,
    input  cpu_ready, cpu_rvalid, cpu_rdata, mem_req, mem_addr
  );
endinterface

// File: rtl/cache_stats.sv
// Saturating hit/miss counters; instantiated by cache_ctrl only under CACHE_CTRL_STATS_EN.
module cache_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        hit,
  input  logic        miss,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && hit_count != '1)
        hit_count <= hit_count + 32'd1;
      if (miss && miss_count != '1)
        miss_count <= miss_count + 32'd1;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped read-only cache controller: lookup, memory refill and invalidate-all sweep.
// Optional hit/miss counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int INDEX_W = DEFAULT_INDEX_W,
  parameter int TAG_W   = ADDR_W - INDEX_W - 2
) (
  input  logic               clk,
  input  logic               rst,
  cache_ctrl_if.master       bus,
  input  logic               flush,
  output logic [INDEX_W-1:0] ram_index,
  output logic               valid_in,
  output logic               valid_write,
  input  logic               valid_out,
  output logic [TAG_W-1:0]   tag_in,
  output logic               tag_write,
  input  logic [TAG_W-1:0]   tag_out,
  output logic [31:0]        data_in,
  output logic               data_write,
  input  logic [31:0]        data_out
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);

  cache_state_t state, state_nx;

  logic [INDEX_W-1:0] count;
  logic [INDEX_W-1:0] lat_index;
  logic [TAG_W-1:0]   lat_tag;
  logic [31:0]        cap_word;
  logic               pend;

  logic count_clr, count_inc, pend_clr, addr_load, word_load;
  logic lookup_hit;

  logic [63:0]        addr_wide, idx_wide, tag_wide;
  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               unused_bits;

  assign addr_wide   = 64'(bus.cpu_addr);
  assign idx_wide    = addr_index(addr_wide, INDEX_W);
  assign tag_wide    = addr_tag(addr_wide, INDEX_W);
  assign req_index   = idx_wide[INDEX_W-1:0];
  assign req_tag     = tag_wide[TAG_W-1:0];
  assign unused_bits = ^{idx_wide[63:INDEX_W], tag_wide[63:TAG_W]};

  assign lookup_hit = (valid_out == PRESENT) && (tag_out == lat_tag);

  // NOTE: state and datapath registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FLUSH;
      count     <= '0;
      lat_index <= '0;
      lat_tag   <= '0;
      cap_word  <= '0;
      pend      <= 1'b0;
    end else begin
      state <= state_nx;
      if (count_clr)
        count <= '0;
      else if (count_inc)
        count <= count + 1'b1;
      if (addr_load) begin
        lat_index <= req_index;
        lat_tag   <= req_tag;
      end
      if (word_load)
        cap_word <= bus.mem_rdata;
      if (pend_clr)
        pend <= 1'b0;
      else if (flush && state != IDLE && state != FLUSH)
        pend <= 1'b1;
    end
  end

  logic              ready_c, rvalid_c, mreq_c;
  logic [31:0]       rdata_c;
  logic [ADDR_W-1:0] maddr_c;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_nx    = state;
    count_clr   = 1'b0;
    count_inc   = 1'b0;
    pend_clr    = 1'b0;
    addr_load   = 1'b0;
    word_load   = 1'b0;
    ready_c     = 1'b0;
    rvalid_c    = 1'b0;
    rdata_c     = '0;
    mreq_c      = 1'b0;
    maddr_c     = '0;
    ram_index   = lat_index;
    valid_in    = ABSENT;
    valid_write = 1'b0;
    tag_in      = '0;
    tag_write   = 1'b0;
    data_in     = '0;
    data_write  = 1'b0;

    unique case (state)
      FLUSH: begin
        ram_index   = count;
        valid_write = 1'b1;
        count_inc   = 1'b1;
        if (count == '1)
          state_nx = IDLE;
      end
      IDLE: begin
        ram_index = req_index;
        if (flush || pend) begin
          state_nx  = FLUSH;
          count_clr = 1'b1;
          pend_clr  = 1'b1;
        end else begin
          ready_c = 1'b1;
          if (bus.cpu_req) begin
            addr_load = 1'b1;
            state_nx  = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        if (lookup_hit) begin
          rvalid_c = 1'b1;
          rdata_c  = data_out;
          state_nx = IDLE;
        end else begin
          state_nx = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mreq_c  = 1'b1;
        maddr_c = {lat_tag, lat_index, 2'b00};
        if (bus.mem_ack) begin
          word_load = 1'b1;
          state_nx  = REFILL;
        end
      end
      REFILL: begin
        valid_in    = PRESENT;
        valid_write = 1'b1;
        tag_in      = lat_tag;
        tag_write   = 1'b1;
        data_in     = cap_word;
        data_write  = 1'b1;
        state_nx    = RESP;
      end
      RESP: begin
        rvalid_c = 1'b1;
        rdata_c  = cap_word;
        state_nx = IDLE;
      end
      default: state_nx = FLUSH;
    endcase

    // Outputs are forced low while rst is high so an in-flight refill request
    // drops without waiting for a clock edge.
    if (rst) begin
      ready_c     = 1'b0;
      rvalid_c    = 1'b0;
      rdata_c     = '0;
      mreq_c      = 1'b0;
      maddr_c     = '0;
      ram_index   = '0;
      valid_in    = ABSENT;
      valid_write = 1'b0;
      tag_in      = '0;
      tag_write   = 1'b0;
      data_in     = '0;
      data_write  = 1'b0;
    end
  end

  assign bus.cpu_ready  = ready_c;
  assign bus.cpu_rvalid = rvalid_c;
  assign bus.cpu_rdata  = rdata_c;
  assign bus.mem_req    = mreq_c;
  assign bus.mem_addr   = maddr_c;

`ifdef CACHE_CTRL_STATS_EN
  cache_stats u_stats (
    .clk        (clk),
    .rst        (rst),
    .hit        (state == LOOKUP && lookup_hit),
    .miss       (state == LOOKUP && !lookup_hit),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl with behavioural valid/tag/data arrays.
module tb_cache_ctrl;

  localparam int ADDR_W  = 32;
  localparam int INDEX_W = 6;
  localparam int TAG_W   = 24;
  localparam int LINES   = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  logic [INDEX_W-1:0] ram_index;
  logic               valid_in, valid_write, tag_write, data_write;
  logic [TAG_W-1:0]   tag_in;
  logic [31:0]        data_in;
  logic               valid_out = 1'b0;
  logic [TAG_W-1:0]   tag_out = '0;
  logic [31:0]        data_out = '0;
`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  cache_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  cache_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .flush       (flush),
    .ram_index   (ram_index),
    .valid_in    (valid_in),
    .valid_write (valid_write),
    .valid_out   (valid_out),
    .tag_in      (tag_in),
    .tag_write   (tag_write),
    .tag_out     (tag_out),
    .data_in     (data_in),
    .data_write  (data_write),
    .data_out    (data_out)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Arrays start with every line valid and tagged 1, so a skipped sweep would
  // make the first read of 0x104 hit stale contents.
  logic             vmem [LINES] = '{default: 1'b1};
  logic [TAG_W-1:0] tmem [LINES] = '{default: 24'd1};
  logic [31:0]      dmem [LINES] = '{default: 32'hBAD0_BAD0};

  always @(posedge clk) begin
    valid_out <= vmem[ram_index];
    tag_out   <= tmem[ram_index];
    data_out  <= dmem[ram_index];
    if (valid_write) vmem[ram_index] <= valid_in;
    if (tag_write)   tmem[ram_index] <= tag_in;
    if (data_write)  dmem[ram_index] <= data_in;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at the start of the first sweep cycle; returns one tick into the following IDLE cycle.
  task automatic check_sweep(input string tag);
    for (int i = 0; i < LINES; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check({tag, " sweep"},
            {valid_write, valid_in, tag_write, data_write, bus.cpu_ready, bus.mem_req, ram_index},
            {6'b100000, 6'(i)});
    end
    @(negedge clk);
    #1;
    check({tag, " ready after sweep"}, {bus.cpu_ready, valid_write}, 2'b10);
  endtask

  // Entered in an IDLE cycle with cpu_ready expected high; returns at the next IDLE negedge.
  task automatic read_txn(input string tag, input logic [31:0] addr, input bit expect_hit,
                          input int ack_wait, input logic [31:0] mem_word,
                          input logic [31:0] exp_data, input bit flush_pulse);
    logic [31:0]        exp_addr;
    logic [INDEX_W-1:0] exp_idx;
    logic [TAG_W-1:0]   exp_tag;
    exp_addr = {addr[31:2], 2'b00};
    exp_idx  = addr[7:2];
    exp_tag  = addr[31:8];

    bus.cpu_req  = 1'b1;
    bus.cpu_addr = addr;
    #1;
    check({tag, " accept"}, {bus.cpu_ready, ram_index}, {1'b1, exp_idx});

    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    if (expect_hit) begin
      check({tag, " hit resp"}, {bus.cpu_rvalid, bus.mem_req, bus.cpu_rdata}, {2'b10, exp_data});
    end else begin
      check({tag, " lookup miss"}, {bus.cpu_rvalid, bus.mem_req}, 2'b00);
      for (int w = 0; w < ack_wait; w++) begin
        @(negedge clk);
        flush = (w == 0) ? flush_pulse : 1'b0;
        #1;
        check({tag, " mem_req"}, {bus.mem_req, bus.mem_addr}, {1'b1, exp_addr});
      end
      @(negedge clk);
      flush         = 1'b0;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = mem_word;
      #1;
      check({tag, " mem_req at ack"}, {bus.mem_req, bus.mem_addr}, {1'b1, exp_addr});

      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
      #1;
      check({tag, " refill strobes"},
            {valid_write, tag_write, data_write, valid_in, bus.mem_req, ram_index},
            {5'b11110, exp_idx});
      check({tag, " refill tag"}, tag_in, exp_tag);
      check({tag, " refill data"}, data_in, mem_word);

      @(negedge clk);
      #1;
      check({tag, " miss resp"}, {bus.cpu_rvalid, bus.cpu_rdata}, {1'b1, exp_data});
    end
    @(negedge clk);
  endtask

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    repeat (3) @(negedge clk);
    #1;
    check("reset outputs",
          {bus.cpu_ready, bus.cpu_rvalid, bus.mem_req, valid_write, tag_write, data_write, ram_index},
          '0);

    @(negedge clk);
    rst = 1'b0;
    check_sweep("post-reset");

    read_txn("cold 0x104", 32'h0000_0104, 1'b0, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
`ifdef CACHE_CTRL_STATS_EN
    check("stats after cold", {hit_count, miss_count}, {32'd0, 32'd1});
`endif
    read_txn("repeat 0x104", 32'h0000_0104, 1'b1, 0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    #1;
    check("no mem_req after hit", {bus.mem_req, bus.cpu_ready}, 2'b01);
`ifdef CACHE_CTRL_STATS_EN
    check("stats after hit", {hit_count, miss_count}, {32'd1, 32'd1});
`endif

    read_txn("conflict 0x204", 32'h0000_0204, 1'b0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
    read_txn("evicted 0x104", 32'h0000_0104, 1'b0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);

    read_txn("flush in miss", 32'h0000_0308, 1'b0, 3, 32'h1234_5678, 32'h1234_5678, 1'b1);
    #1;
    check("pending flush blocks accept", {bus.cpu_ready, valid_write}, 2'b00);
    @(negedge clk);
    check_sweep("pending flush");
    read_txn("0x104 after flush", 32'h0000_0104, 1'b0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
`ifdef CACHE_CTRL_STATS_EN
    check("stats survive flush", {hit_count, miss_count}, {32'd1, 32'd5});
`endif

    // Reset while the refill request is outstanding.
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0000_040C;
    #1;
    check("rst txn accept", bus.cpu_ready, 1'b1);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    #1;
    check("rst txn mem_req", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h0000_040C});
    #1;
    rst = 1'b1;
    #1;
    check("mem_req drops on rst", {bus.mem_req, valid_write, bus.cpu_ready}, 3'b000);
    repeat (2) @(negedge clk);
    rst           = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1111_1111;
    check_sweep("rst mid-refill");
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
`ifdef CACHE_CTRL_STATS_EN
    check("stats cleared by rst", {hit_count, miss_count}, 64'd0);
`endif
    read_txn("0x40C after rst", 32'h0000_040C, 1'b0, 1, 32'h2222_2222, 32'h2222_2222, 1'b0);
`ifdef CACHE_CTRL_STATS_EN
    check("stats after rst read", {hit_count, miss_count}, {32'd0, 32'd1});
`endif
    read_txn("0x40C hit", 32'h0000_040C, 1'b1, 0, 32'h0, 32'h2222_2222, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
